// File: rtl/lhn_muldiv_pkg.sv
// lhn_muldiv_pkg: shared encodings for the iterative MUL/DIV unit.
// Op codes, FSM states and SR flag bit positions.
package lhn_muldiv_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    localparam int FLG_C = 3;
    localparam int FLG_N = 2;
    localparam int FLG_V = 1;
    localparam int FLG_Z = 0;

endpackage

// File: rtl/lhn_muldiv_if.sv
// lhn_muldiv_if: request/result bundle between the pipeline
// controller (master) and the MUL/DIV unit (slave).
interface lhn_muldiv_if #(
    parameter int DW = 14
);

    logic          start;
    logic          op;
    logic          sgn;
    logic [DW-1:0] opA;
    logic [DW-1:0] opB;
    logic          busy;
    logic          done;
    logic [DW-1:0] res_hi;
    logic [DW-1:0] res_lo;
    logic [3:0]    flags;
    logic          div_by_zero;

    modport master (
        output start, op, sgn, opA, opB,
        input  busy, done, res_hi, res_lo, flags, div_by_zero
    );

    modport slave (
        input  start, op, sgn, opA, opB,
        output busy, done, res_hi, res_lo, flags, div_by_zero
    );

endinterface

// File: rtl/lhn_muldiv_signfix.sv
// lhn_muldiv_signfix: conditional two's-complement negate.
// Used as |x| (neg = sgn & msb) and for result sign correction.
module lhn_muldiv_signfix #(
    parameter int W = 14
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);

    assign y = neg ? -x : x;

endmodule

// File: rtl/lhn_muldiv_unit.sv
// lhn_muldiv_unit: iterative shift-add MUL / restoring DIV, DW bits.
// Optional macro LHN_MULDIV_EARLY_EXIT_EN: MUL ends once multiplier is exhausted.
module lhn_muldiv_unit
    import lhn_muldiv_pkg::*;
#(
    parameter  int DW = 14,
    localparam int CW = $clog2(DW + 1)
) (
    input  logic       Clock_pin,
    input  logic       Resetn_pin,
    lhn_muldiv_if.slave bus
);

    localparam logic [DW-1:0] MIN_V = {1'b1, {(DW-1){1'b0}}};

    state_t          state_q, state_d;
    logic            op_q, sgn_q, neg_q, nrem_q, ovf_q, dbz_q;
    logic [CW-1:0]   cnt_q;
    logic [2*DW-1:0] acc_q, mc_q;
    logic [DW-1:0]   b_q;
    logic            done_q, dbz_o;
    logic [DW-1:0]   hi_q, lo_q;
    logic [3:0]      fl_q;

    logic [DW-1:0]   a_mag, b_mag, q_fix, r_fix;
    logic [2*DW-1:0] p_fix;
    logic            dz, last, early, ge, mul_ovf;
    logic [DW:0]     shf;
    logic [DW-1:0]   dif;
    logic [2*DW-1:0] div_nxt;
    logic [DW-1:0]   hi_d, lo_d;
    logic [3:0]      fl_d;

    lhn_muldiv_signfix #(.W(DW)) u_abs_a (
        .x(bus.opA), .neg(bus.sgn & bus.opA[DW-1]), .y(a_mag)
    );
    lhn_muldiv_signfix #(.W(DW)) u_abs_b (
        .x(bus.opB), .neg(bus.sgn & bus.opB[DW-1]), .y(b_mag)
    );
    lhn_muldiv_signfix #(.W(DW)) u_fix_q (
        .x(acc_q[DW-1:0]), .neg(neg_q), .y(q_fix)
    );
    lhn_muldiv_signfix #(.W(DW)) u_fix_r (
        .x(acc_q[2*DW-1:DW]), .neg(nrem_q), .y(r_fix)
    );
    lhn_muldiv_signfix #(.W(2*DW)) u_fix_p (
        .x(acc_q), .neg(neg_q), .y(p_fix)
    );

    assign dz = (bus.op == OP_DIV) && (bus.opB == '0);

`ifdef LHN_MULDIV_EARLY_EXIT_EN
    assign early = (op_q == OP_MUL) && (b_q[DW-1:1] == '0);
`else
    assign early = 1'b0;
`endif

    assign last = (cnt_q == CW'(DW - 1)) || early;

    // remainder lives in acc[hi], dividend/quotient shifts through acc[lo]
    assign shf     = acc_q[2*DW-1:DW-1];
    assign ge      = shf >= {1'b0, b_q};
    assign dif     = shf[DW-1:0] - b_q;
    assign div_nxt = {ge ? dif : shf[DW-1:0], acc_q[DW-2:0], ge};

    assign mul_ovf = p_fix[2*DW-1:DW] !=
                     (sgn_q ? {DW{p_fix[DW-1]}} : {DW{1'b0}});

    // state register
    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) state_q <= IDLE;
        else             state_q <= state_d;
    end

    // next-state: zero divisor skips the iteration phase
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.start) state_d = dz ? FIN : RUN;
            RUN:  if (last) state_d = FIN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // final result selection and SR-ordered flags
    always_comb begin
        hi_d = q_fix;
        lo_d = r_fix;
        fl_d = '0;
        if (dbz_q) begin
            hi_d        = '1;
            lo_d        = acc_q[DW-1:0];
            fl_d[FLG_V] = 1'b1;
            fl_d[FLG_N] = sgn_q;
        end else if (op_q == OP_MUL) begin
            hi_d        = p_fix[2*DW-1:DW];
            lo_d        = p_fix[DW-1:0];
            fl_d[FLG_Z] = (p_fix == '0);
            fl_d[FLG_N] = sgn_q & p_fix[2*DW-1];
            fl_d[FLG_C] = mul_ovf;
            fl_d[FLG_V] = mul_ovf;
        end else begin
            fl_d[FLG_Z] = (q_fix == '0);
            fl_d[FLG_N] = sgn_q & q_fix[DW-1];
            fl_d[FLG_V] = ovf_q;
        end
    end

    // operand capture, per-clock iteration and result registers
    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            op_q   <= 1'b0;
            sgn_q  <= 1'b0;
            neg_q  <= 1'b0;
            nrem_q <= 1'b0;
            ovf_q  <= 1'b0;
            dbz_q  <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            mc_q   <= '0;
            b_q    <= '0;
            done_q <= 1'b0;
            dbz_o  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            fl_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: if (bus.start) begin
                    op_q   <= bus.op;
                    sgn_q  <= bus.sgn;
                    neg_q  <= bus.sgn & (bus.opA[DW-1] ^ bus.opB[DW-1]);
                    nrem_q <= bus.sgn & bus.opA[DW-1];
                    ovf_q  <= bus.sgn && (bus.opA == MIN_V) && (bus.opB == '1);
                    dbz_q  <= dz;
                    dbz_o  <= 1'b0;
                    cnt_q  <= '0;
                    b_q    <= b_mag;
                    mc_q   <= {{DW{1'b0}}, a_mag};
                    acc_q  <= (bus.op == OP_DIV) ?
                              {{DW{1'b0}}, dz ? bus.opA : a_mag} : '0;
                end
                RUN: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (op_q == OP_MUL) begin
                        acc_q <= acc_q + (b_q[0] ? mc_q : '0);
                        mc_q  <= mc_q << 1;
                        b_q   <= b_q >> 1;
                    end else begin
                        acc_q <= div_nxt;
                    end
                end
                FIN: begin
                    hi_q   <= hi_d;
                    lo_q   <= lo_d;
                    fl_q   <= fl_d;
                    done_q <= 1'b1;
                    dbz_o  <= dbz_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.res_hi      = hi_q;
    assign bus.res_lo      = lo_q;
    assign bus.flags       = fl_q;
    assign bus.div_by_zero = dbz_o;

endmodule

// File: tb/tb_lhn_muldiv_unit.sv
// tb_lhn_muldiv_unit: directed vectors for lhn_muldiv_unit (DW=14).
// Latency counted in clock edges after the accepting edge.
module tb_lhn_muldiv_unit;

    localparam int DW = 14;

`ifdef LHN_MULDIV_EARLY_EXIT_EN
    localparam int EE_LAT = 3;
`else
    localparam int EE_LAT = 15;
`endif

    logic clk;
    logic rstn;
    int   total;
    int   bad;
    int   lat;

    lhn_muldiv_if #(.DW(DW)) bus ();

    lhn_muldiv_unit #(.DW(DW)) dut (
        .Clock_pin  (clk),
        .Resetn_pin (rstn),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int n_out);
        n_out = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                n_out = n;
                break;
            end
        end
    endtask

    task automatic run(input logic o, input logic s,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       output int n_out);
        @(negedge clk);
        bus.op    = o;
        bus.sgn   = s;
        bus.opA   = a;
        bus.opB   = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
        chk("dbz_cleared", 32'(bus.div_by_zero), 32'd0);
        wait_done(n_out);
        chk("busy_at_done", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        clk       = 1'b0;
        rstn      = 1'b0;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.sgn   = 1'b0;
        bus.opA   = '0;
        bus.opB   = '0;

        @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_hi", 32'(bus.res_hi), 32'd0);
        chk("rst_lo", 32'(bus.res_lo), 32'd0);
        chk("rst_flags", 32'(bus.flags), 32'd0);
        chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // unsigned MUL 100*200 = 20000 = 1*2^14 + 3616
        run(1'b0, 1'b0, 14'd100, 14'd200, lat);
        chk("umul_lat", 32'(lat), 32'd15);
        chk("umul_hi", 32'(bus.res_hi), 32'd1);
        chk("umul_lo", 32'(bus.res_lo), 32'd3616);
        chk("umul_flags", 32'(bus.flags), 32'b1010);

        // signed MUL -3*5 = -15
        run(1'b0, 1'b1, 14'h3FFD, 14'd5, lat);
        chk("smul_lat", 32'(lat), 32'd15);
        chk("smul_hi", 32'(bus.res_hi), 32'h3FFF);
        chk("smul_lo", 32'(bus.res_lo), 32'h3FF1);
        chk("smul_flags", 32'(bus.flags), 32'b0100);

        // unsigned DIV 1000/7 = 142 r 6
        run(1'b1, 1'b0, 14'd1000, 14'd7, lat);
        chk("udiv_lat", 32'(lat), 32'd15);
        chk("udiv_q", 32'(bus.res_hi), 32'd142);
        chk("udiv_r", 32'(bus.res_lo), 32'd6);
        chk("udiv_flags", 32'(bus.flags), 32'b0000);

        // signed DIV -17/5 = -3 r -2
        run(1'b1, 1'b1, 14'h3FEF, 14'd5, lat);
        chk("sdiv_q", 32'(bus.res_hi), 32'h3FFD);
        chk("sdiv_r", 32'(bus.res_lo), 32'h3FFE);
        chk("sdiv_flags", 32'(bus.flags), 32'b0100);

        // divide by zero: accept edge goes straight to FIN
        run(1'b1, 1'b0, 14'd123, 14'd0, lat);
        chk("dz_lat", 32'(lat), 32'd1);
        chk("dz_hi", 32'(bus.res_hi), 32'h3FFF);
        chk("dz_lo", 32'(bus.res_lo), 32'd123);
        chk("dz_flags", 32'(bus.flags), 32'b0010);
        chk("dz_sticky", 32'(bus.div_by_zero), 32'd1);
        @(posedge clk);
        #1;
        chk("dz_hold", 32'(bus.div_by_zero), 32'd1);

        // next start clears dbz; 0x1234*3 = 0x369C
        run(1'b0, 1'b0, 14'h1234, 14'd3, lat);
        chk("ee_lat", 32'(lat), 32'(EE_LAT));
        chk("ee_hi", 32'(bus.res_hi), 32'd0);
        chk("ee_lo", 32'(bus.res_lo), 32'h369C);
        chk("ee_dbz", 32'(bus.div_by_zero), 32'd0);

        // signed MIN / -1 wraps
        run(1'b1, 1'b1, 14'h2000, 14'h3FFF, lat);
        chk("min_q", 32'(bus.res_hi), 32'h2000);
        chk("min_r", 32'(bus.res_lo), 32'd0);
        chk("min_flags", 32'(bus.flags), 32'b0110);

        // start while busy is ignored: 7*9 = 63
        @(negedge clk);
        bus.op    = 1'b0;
        bus.sgn   = 1'b0;
        bus.opA   = 14'd7;
        bus.opB   = 14'd9;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 4) begin
                bus.start = 1'b1;
                bus.op    = 1'b1;
                bus.opA   = 14'd50;
                bus.opB   = 14'd3;
            end
            if (n == 5) bus.start = 1'b0;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        chk("ign_lat", 32'(lat), 32'd15);
        chk("ign_hi", 32'(bus.res_hi), 32'd0);
        chk("ign_lo", 32'(bus.res_lo), 32'd63);
        @(posedge clk);
        #1;
        chk("ign_idle", 32'(bus.busy), 32'd0);

        // asynchronous reset mid-operation
        @(negedge clk);
        bus.op    = 1'b0;
        bus.opA   = 14'd100;
        bus.opB   = 14'd200;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_hi", 32'(bus.res_hi), 32'd0);
        chk("arst_lo", 32'(bus.res_lo), 32'd0);
        chk("arst_flags", 32'(bus.flags), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // clean operation after reset: 11*13 = 143
        run(1'b0, 1'b0, 14'd11, 14'd13, lat);
        chk("post_lat", 32'(lat), 32'd15);
        chk("post_hi", 32'(bus.res_hi), 32'd0);
        chk("post_lo", 32'(bus.res_lo), 32'd143);
        chk("post_flags", 32'(bus.flags), 32'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
